ioctl_loader_bridge: RTL and testbench

Multi-channel, buffered successor to the single-register HPS download handshake in the core top level. It sits between `hps_io` ioctl outputs and one or more core-side loader ports. It accepts byte writes from the HPS into a FIFO and asserts `ioctl_wait` before the FIFO can overflow. It replays the writes to the core over a req/ack handshake, keeps a sticky per-channel done flag, and drives a stretched activity LED.

---
 rtl/ioctl_loader_bridge.sv | 163 ++++++++++++++++
 tb/tb_ioctl_loader_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader_bridge.sv
// Buffers HPS ioctl byte writes in a small FIFO and replays them to core-side
// loaders over a req/ack handshake, with sticky per-channel done flags and an activity LED.
module ioctl_loader_bridge #(
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int NCH         = 2,
   parameter int ACT_TIMEOUT = 1000000,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [DATA_W-1:0] ioctl_dout,
   output logic              ioctl_wait,
   output logic              ldr_wr,
   input  logic              ldr_ack,
   output logic [CH_W-1:0]   ldr_ch,
   output logic [ADDR_W-1:0] ldr_adr,
   output logic [DATA_W-1:0] ldr_dat,
   output logic [NCH-1:0]    ldr_oe,
   output logic [NCH-1:0]    ldr_done,
   output logic              overflow,
   output logic              act_led
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int LED_W = $clog2(ACT_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   function automatic logic [LED_W-1:0] led_sat_inc(input logic [LED_W-1:0] c);
      return (c >= LED_W'(ACT_TIMEOUT)) ? c : c + 1'b1;
   endfunction

   logic [CH_W-1:0]   mem_ch  [DEPTH];
   logic [ADDR_W-1:0] mem_adr [DEPTH];
   logic [DATA_W-1:0] mem_dat [DEPTH];

   logic [PTR_W-1:0]  wptr, rptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [1:0]        state;
   logic              ack_q;
   logic              dl_q, active, draining;
   logic [CH_W-1:0]   cur_ch;
   logic [LED_W-1:0]  led_cnt;

   logic              idx_ok, acc, full, push, pop;
   logic              dl_rise, dl_fall, drain_go;
   logic [CH_W-1:0]   idx_ch;

   assign idx_ok    = ({24'd0, ioctl_index} < NCH);
   assign idx_ch    = ioctl_index[CH_W-1:0];
   assign acc       = ioctl_wr & ioctl_download & idx_ok & ~ldr_done[idx_ch];
   assign full      = (count == CNT_W'(DEPTH));
   assign push      = acc & ~full;
   assign pop       = (state == S_REQ) & ldr_ack & ~ack_q;
   assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   // The queue is only ever empty outside REQ, so an empty queue means the replay is finished.
   assign drain_go  = (draining | (dl_fall & active)) & (count == '0) & (state != S_REQ);

   assign act_led   = (led_cnt < LED_W'(ACT_TIMEOUT));

   always_comb begin
      ldr_oe = '0;
      if (active) ldr_oe[cur_ch] = 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem_ch[wptr]  <= idx_ch;
         mem_adr[wptr] <= ioctl_addr;
         mem_dat[wptr] <= ioctl_dout;
      end
   end

   // Wait threshold at DEPTH-1 leaves room for a strobe already in flight from the HPS.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count      <= count_nxt;
         ioctl_wait <= (count_nxt >= CNT_W'(DEPTH - 1));
         if (acc & full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         dl_q     <= 1'b0;
         active   <= 1'b0;
         draining <= 1'b0;
         cur_ch   <= '0;
         ldr_done <= '0;
      end else begin
         dl_q <= ioctl_download;
         if (drain_go) begin
            ldr_done[cur_ch] <= 1'b1;
            active           <= 1'b0;
            draining         <= 1'b0;
         end else if (dl_fall & active) begin
            draining <= 1'b1;
         end else if (dl_rise & ~draining) begin
            cur_ch <= idx_ch;
            active <= idx_ok;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         ldr_wr  <= 1'b0;
         ldr_ch  <= '0;
         ldr_adr <= '0;
         ldr_dat <= '0;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= ldr_ack;
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  ldr_ch  <= mem_ch[rptr];
                  ldr_adr <= mem_adr[rptr];
                  ldr_dat <= mem_dat[rptr];
                  ldr_wr  <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (pop) begin
                  ldr_wr <= 1'b0;
                  state  <= S_GAP;
               end
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n)  led_cnt <= LED_W'(ACT_TIMEOUT);
      else if (acc)  led_cnt <= '0;
      else           led_cnt <= led_sat_inc(led_cnt);
   end

endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Self-checking bench for ioctl_loader_bridge: directed scenarios plus random loads
// compared against an in-order queue model of accepted writes.
`timescale 1ns/1ps
module tb_ioctl_loader_bridge;

   localparam int ADDR_W      = 19;
   localparam int DATA_W      = 8;
   localparam int DEPTH       = 4;
   localparam int NCH         = 2;
   localparam int ACT_TIMEOUT = 20;
   localparam int CH_W        = 1;

   logic              clk_sys        = 1'b0;
   logic              reset_n        = 1'b0;
   logic              ioctl_download = 1'b0;
   logic [7:0]        ioctl_index    = 8'd0;
   logic              ioctl_wr       = 1'b0;
   logic [ADDR_W-1:0] ioctl_addr     = '0;
   logic [DATA_W-1:0] ioctl_dout     = '0;
   logic              ldr_ack        = 1'b0;
   logic              ioctl_wait, ldr_wr, overflow, act_led;
   logic [CH_W-1:0]   ldr_ch;
   logic [ADDR_W-1:0] ldr_adr;
   logic [DATA_W-1:0] ldr_dat;
   logic [NCH-1:0]    ldr_oe, ldr_done;

   ioctl_loader_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH), .ACT_TIMEOUT(ACT_TIMEOUT)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ldr_wr(ldr_wr), .ldr_ack(ldr_ack),
      .ldr_ch(ldr_ch), .ldr_adr(ldr_adr), .ldr_dat(ldr_dat), .ldr_oe(ldr_oe),
      .ldr_done(ldr_done), .overflow(overflow), .act_led(act_led)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [7:0]        ch;
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
   } ent_t;

   ent_t         exp_q[$];
   int           rise_q[$];
   bit [NCH-1:0] m_done = '0;
   bit           m_ovf  = 1'b0;
   int           n_checks = 0, n_fail = 0, n_deliv = 0;
   int           cyc = 0, last_fall_cyc = 0;
   bit           resp_en = 1'b1;
   int           ack_dly = 1;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Core-side responder: raises ack ack_dly cycles after seeing a request, for one cycle.
   initial begin : responder
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (resp_en) begin
            if (ldr_ack) begin
               ldr_ack = 1'b0;
               wcnt    = 0;
            end else if (ldr_wr) begin
               if (wcnt >= ack_dly) begin
                  ldr_ack = 1'b1;
                  wcnt    = 0;
               end else wcnt++;
            end else wcnt = 0;
         end
      end
   end

   // Each request must match the oldest accepted write; completion retires it.
   initial begin : monitor
      logic wr_prev;
      wr_prev = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if (ldr_wr && !wr_prev) begin
               rise_q.push_back(cyc);
               if (exp_q.size() == 0) check_eq("spurious_ldr_wr", 64'(ldr_wr), 64'd0);
               else begin
                  check_eq("ldr_ch", 64'(ldr_ch), 64'(exp_q[0].ch));
                  check_eq("ldr_adr", 64'(ldr_adr), 64'(exp_q[0].adr));
                  check_eq("ldr_dat", 64'(ldr_dat), 64'(exp_q[0].dat));
                  check_eq("ldr_oe_during_req", 64'(ldr_oe[ldr_ch]), 64'd1);
               end
            end
            if (!ldr_wr && wr_prev) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               n_deliv++;
               last_fall_cyc = cyc;
            end
         end
         wr_prev = ldr_wr;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_index    = 8'd0;
      tick(3);
      exp_q.delete();
      m_done  = '0;
      m_ovf   = 1'b0;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic start_dl(input int idx);
      ioctl_index    = 8'(idx);
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic wr_byte(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat,
                          input bit gated);
      int   guard;
      int   ix;
      bit   accept;
      ent_t e;
      guard = 0;
      if (gated) begin
         while (ioctl_wait && guard < 200) begin
            ioctl_wr = 1'b0;
            tick();
            guard++;
         end
         if (ioctl_wait) check_eq("wait_timeout", 64'(ioctl_wait), 64'd0);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = adr;
      ioctl_dout = dat;
      ix     = int'(ioctl_index);
      accept = ioctl_download && (ix < NCH) && !m_done[ix];
      if (accept) begin
         if (!gated && exp_q.size() >= DEPTH) m_ovf = 1'b1;
         else begin
            e.ch  = ioctl_index;
            e.adr = adr;
            e.dat = dat;
            exp_q.push_back(e);
         end
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic end_dl();
      int guard;
      int ix;
      guard          = 0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      tick();
      while (exp_q.size() != 0 && guard < 2000) begin
         tick();
         guard++;
      end
      check_eq("drain_complete", 64'(exp_q.size()), 64'd0);
      tick(2);
      ix = int'(ioctl_index);
      if (ix < NCH) m_done[ix] = 1'b1;
      check_eq("ldr_done", 64'(ldr_done), 64'(m_done));
      check_eq("ldr_oe_after_done", 64'(ldr_oe), 64'd0);
   endtask

   initial begin : main
      int d0, t0, guard, n;
      tick(3);
      check_eq("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
      check_eq("rst_ldr_wr", 64'(ldr_wr), 64'd0);
      check_eq("rst_ldr_ch", 64'(ldr_ch), 64'd0);
      check_eq("rst_ldr_adr", 64'(ldr_adr), 64'd0);
      check_eq("rst_ldr_dat", 64'(ldr_dat), 64'd0);
      check_eq("rst_ldr_oe", 64'(ldr_oe), 64'd0);
      check_eq("rst_ldr_done", 64'(ldr_done), 64'd0);
      check_eq("rst_overflow", 64'(overflow), 64'd0);
      check_eq("rst_act_led", 64'(act_led), 64'd0);
      reset_n = 1'b1;
      tick();

      // Basic load on channel 0
      resp_en = 1'b1;
      ack_dly = 1;
      d0 = n_deliv;
      rise_q.delete();
      start_dl(0);
      check_eq("ldr_oe_active0", 64'(ldr_oe), 64'd1);
      t0 = cyc;
      wr_byte(19'd0, 8'hA5, 1'b1);
      wr_byte(19'd1, 8'h5A, 1'b1);
      wr_byte(19'd2, 8'hFF, 1'b1);
      ioctl_download = 1'b0;
      guard = 0;
      while (!ldr_done[0] && guard < 200) begin
         tick();
         guard++;
      end
      check_eq("done_basic", 64'(ldr_done), 64'd1);
      check_eq("done_latency", 64'(cyc - last_fall_cyc), 64'd1);
      check_eq("ldr_oe_after_basic", 64'(ldr_oe), 64'd0);
      check_eq("deliv_basic", 64'(n_deliv - d0), 64'd3);
      check_eq("rise_count_basic", 64'(rise_q.size()), 64'd3);
      if (rise_q.size() >= 3) begin
         check_eq("first_req_latency", 64'(rise_q[0] - t0), 64'd2);
         check_eq("req_spacing_1", 64'(rise_q[1] - rise_q[0]), 64'd4);
         check_eq("req_spacing_2", 64'(rise_q[2] - rise_q[1]), 64'd4);
      end
      m_done[0] = 1'b1;

      // Backpressure: strobes gated by ioctl_wait, slow acknowledge
      do_reset();
      ack_dly = 10;
      d0 = n_deliv;
      start_dl(0);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) check_eq("wait_at_count2", 64'(ioctl_wait), 64'd0);
         if (i == 3) check_eq("wait_at_count3", 64'(ioctl_wait), 64'd1);
         wr_byte(ADDR_W'(16 + i), DATA_W'(8'h30 + i), 1'b1);
      end
      end_dl();
      check_eq("deliv_backpressure", 64'(n_deliv - d0), 64'd6);
      check_eq("overflow_backpressure", 64'(overflow), 64'(m_ovf));

      // Overflow: wait ignored, no acknowledge
      do_reset();
      resp_en = 1'b0;
      ldr_ack = 1'b0;
      d0 = n_deliv;
      start_dl(0);
      for (int i = 0; i < 5; i++) wr_byte(ADDR_W'(i), DATA_W'(8'hC0 + i), 1'b0);
      tick();
      check_eq("overflow_set", 64'(overflow), 64'(m_ovf));
      check_eq("wait_when_full", 64'(ioctl_wait), 64'd1);
      resp_en = 1'b1;
      ack_dly = 1;
      end_dl();
      check_eq("deliv_overflow", 64'(n_deliv - d0), 64'd4);

      // Channel gating
      do_reset();
      ack_dly = int'($urandom_range(0, 3));
      start_dl(1);
      check_eq("ldr_oe_active1", 64'(ldr_oe), 64'd2);
      for (int i = 0; i < 3; i++) wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      end_dl();
      d0 = n_deliv;
      start_dl(1);
      for (int i = 0; i < 2; i++) wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      end_dl();
      start_dl(7);
      check_eq("ldr_oe_invalid_idx", 64'(ldr_oe), 64'd0);
      for (int i = 0; i < 2; i++) wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      end_dl();
      check_eq("deliv_gated", 64'(n_deliv - d0), 64'd0);
      check_eq("done_gating", 64'(ldr_done), 64'd2);

      // Ack already high when the request starts
      do_reset();
      resp_en = 1'b0;
      ldr_ack = 1'b1;
      d0 = n_deliv;
      start_dl(0);
      wr_byte(19'h12345, 8'h77, 1'b1);
      tick(3);
      check_eq("stuck_ack_hold_a", 64'(ldr_wr), 64'd1);
      tick(3);
      check_eq("stuck_ack_hold_b", 64'(ldr_wr), 64'd1);
      ldr_ack = 1'b0;
      tick(2);
      check_eq("stuck_ack_hold_c", 64'(ldr_wr), 64'd1);
      ldr_ack = 1'b1;
      tick();
      check_eq("stuck_ack_release", 64'(ldr_wr), 64'd0);
      ldr_ack = 1'b0;
      resp_en = 1'b1;
      ack_dly = 1;
      end_dl();
      check_eq("deliv_stuck_ack", 64'(n_deliv - d0), 64'd1);

      // Reset in the middle of a request
      do_reset();
      start_dl(1);
      for (int i = 0; i < 2; i++) wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      end_dl();
      resp_en = 1'b0;
      start_dl(0);
      for (int i = 0; i < 3; i++) wr_byte(ADDR_W'(i), DATA_W'($urandom), 1'b0);
      tick(2);
      check_eq("pre_reset_ldr_wr", 64'(ldr_wr), 64'd1);
      check_eq("pre_reset_wait", 64'(ioctl_wait), 64'd1);
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      tick();
      check_eq("midrst_ldr_wr", 64'(ldr_wr), 64'd0);
      check_eq("midrst_wait", 64'(ioctl_wait), 64'd0);
      check_eq("midrst_done", 64'(ldr_done), 64'd0);
      check_eq("midrst_act_led", 64'(act_led), 64'd0);
      tick(2);
      exp_q.delete();
      m_done  = '0;
      reset_n = 1'b1;
      resp_en = 1'b1;
      d0 = n_deliv;
      tick(20);
      check_eq("postrst_deliv", 64'(n_deliv - d0), 64'd0);
      check_eq("postrst_ldr_wr", 64'(ldr_wr), 64'd0);

      // Randomized loads on every valid channel plus stray writes to an invalid index
      do_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         ack_dly = int'($urandom_range(0, 4));
         d0 = n_deliv;
         start_dl(ch);
         n = int'($urandom_range(1, 12));
         for (int i = 0; i < n; i++) begin
            tick(int'($urandom_range(0, 2)));
            wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
         end
         end_dl();
         check_eq("deliv_random", 64'(n_deliv - d0), 64'(n));
      end
      start_dl(5);
      for (int i = 0; i < 3; i++) wr_byte(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
      end_dl();
      check_eq("overflow_random", 64'(overflow), 64'(m_ovf));

      // Activity LED stretch
      do_reset();
      ack_dly = 1;
      check_eq("led_idle", 64'(act_led), 64'd0);
      start_dl(0);
      check_eq("led_before_write", 64'(act_led), 64'd0);
      wr_byte(19'd9, 8'h99, 1'b1);
      check_eq("led_rise", 64'(act_led), 64'd1);
      tick(ACT_TIMEOUT - 1);
      check_eq("led_last_on", 64'(act_led), 64'd1);
      tick();
      check_eq("led_expired", 64'(act_led), 64'd0);
      end_dl();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
